// File: rtl/fifo_sync_buffer.sv
// fifo_sync_buffer: single-clock FIFO with occupancy flags, sticky errors,
// standard or first-word-fall-through read, synchronous flush and bypass.
module fifo_sync_buffer #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDRBIT    = 5,
    parameter int FIFO_DEPTH = 32,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_TH   = 28,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_en,
    input  logic                  clear,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDRBIT:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ADDRBIT + 1;
    localparam logic [PW-1:0] DEPTH_C  = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

    if (FIFO_DEPTH != (1 << ADDRBIT)) begin : g_bad_depth
        $error("fifo_sync_buffer: FIFO_DEPTH must equal 2**ADDRBIT");
    end

    logic [DATA_WIDTH-1:0] mem_q [0:FIFO_DEPTH-1];

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  full_d, empty_d, afull_d, aempty_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic                  active;
    logic                  wr_acc, rd_acc;
    logic [ADDRBIT-1:0]    waddr, raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] fwft_head;

    // A full FIFO rejects writes even when a read frees a slot this cycle.
    assign active  = fifo_en && !clear;
    assign wr_acc  = active && write_en && !full_q;
    assign rd_acc  = active && read_en && !empty_q;
    assign waddr   = wptr_q[ADDRBIT-1:0];
    assign raddr_q = rptr_q[ADDRBIT-1:0];
    assign raddr_d = rptr_d[ADDRBIT-1:0];

    assign count_d  = wptr_d - rptr_d;
    assign full_d   = (count_d == DEPTH_C);
    assign empty_d  = (count_d == '0);
    assign afull_d  = (count_d >= AFULL_C);
    assign aempty_d = (count_d <= AEMPTY_C);

    // The next head may be the word landing in memory on this same edge.
    assign fwft_head = (wr_acc && (waddr == raddr_d)) ? write_data
                                                      : mem_q[raddr_d];

    // Pointer and sticky-error next state; frozen in bypass, zeroed by flush.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (fifo_en) begin
            if (clear) begin
                wptr_d = '0;
                rptr_d = '0;
                ovf_d  = 1'b0;
                unf_d  = 1'b0;
            end else begin
                if (wr_acc) wptr_d = wptr_q + 1'b1;
                if (rd_acc) rptr_d = rptr_q + 1'b1;
                if (write_en && full_q) ovf_d = 1'b1;
                if (read_en && empty_q) unf_d = 1'b1;
            end
        end
    end

    // Read-port next state for bypass, flush, FWFT and standard modes.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        if (!fifo_en) begin
            rdata_d  = write_data;
            rvalid_d = 1'b1;
        end else if (clear) begin
            rvalid_d = 1'b0;
        end else if (FWFT) begin
            rvalid_d = !empty_d;
            if (!empty_d) rdata_d = fwft_head;
        end else begin
            rvalid_d = rd_acc;
            if (rd_acc) rdata_d = mem_q[raddr_q];
        end
    end

    // Storage array; contents are meaningful only between the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[waddr] <= write_data;
    end

    // Control, flag and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign read_data    = rdata_q;
    assign read_valid   = rvalid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// tb_fifo_sync_buffer: queue-based reference model with a scoreboard for the
// standard-read instance plus directed checks of a FWFT instance.
module tb_fifo_sync_buffer;

    localparam int DW    = 12;
    localparam int AB    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          en = 1'b1, clr = 1'b0, we = 1'b0, re = 1'b0;
    logic [DW-1:0] wd = '0;
    logic [DW-1:0] rd;
    logic          rv, full, empty, af, ae, ovf, unf;
    logic [AB:0]   cnt;

    logic          f_en = 1'b1, f_clr = 1'b0, f_we = 1'b0, f_re = 1'b0;
    logic [DW-1:0] f_wd = '0;
    logic [DW-1:0] f_rd;
    logic          f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AB:0]   f_cnt;

    fifo_sync_buffer #(
        .DATA_WIDTH(DW), .ADDRBIT(AB), .FIFO_DEPTH(DEPTH), .FWFT(1'b0),
        .AFULL_TH(28), .AEMPTY_TH(4)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .fifo_en(en), .clear(clr),
        .write_en(we), .write_data(wd), .read_en(re),
        .read_data(rd), .read_valid(rv), .full(full), .empty(empty),
        .almost_full(af), .almost_empty(ae), .count(cnt),
        .overflow(ovf), .underflow(unf)
    );

    fifo_sync_buffer #(
        .DATA_WIDTH(DW), .ADDRBIT(AB), .FIFO_DEPTH(DEPTH), .FWFT(1'b1),
        .AFULL_TH(28), .AEMPTY_TH(4)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .fifo_en(f_en), .clear(f_clr),
        .write_en(f_we), .write_data(f_wd), .read_en(f_re),
        .read_data(f_rd), .read_valid(f_rv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    logic [DW-1:0] mq[$];
    logic [DW-1:0] expq[$];
    bit            m_ovf = 1'b0, m_unf = 1'b0;
    int            errors = 0, checks = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle and advance the reference model for the coming edge.
    task automatic step(bit e, bit c, bit w, logic [DW-1:0] d, bit r);
        int n;
        @(negedge clk);
        en = e; clr = c; we = w; wd = d; re = r;
        if (!e) begin
            expq.push_back(d);
        end else if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            n = mq.size();
            if (r) begin
                if (n == 0) m_unf = 1'b1;
                else expq.push_back(mq.pop_front());
            end
            if (w) begin
                if (n == DEPTH) m_ovf = 1'b1;
                else mq.push_back(d);
            end
        end
    endtask

    // Monitor: status against the model each cycle, data on every valid.
    always @(posedge clk) begin
        #1;
        chk("count", cnt, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("almost_full", af, mq.size() >= 28);
        chk("almost_empty", ae, mq.size() <= 4);
        chk("overflow", ovf, m_ovf);
        chk("underflow", unf, m_unf);
        if (rv) begin
            if (expq.size() == 0) chk("rvalid_extra", rv, 1'b0);
            else chk("read_data", rd, expq.pop_front());
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 32; i++) step(1, 0, 1, DW'(i), 0);
        step(1, 0, 1, 12'h021, 0);
        for (int i = 0; i < 33; i++) step(1, 0, 0, '0, 1);

        step(1, 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, DW'($urandom), 0);
        for (int i = 0; i < 100; i++) step(1, 0, 1, DW'($urandom), 1);

        step(0, 0, 1, 12'h5A5, 0);
        step(0, 1, 1, DW'($urandom), 1);
        step(0, 0, 0, DW'($urandom), 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, '0, 1);

        step(1, 0, 0, '0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 1, DW'($urandom), 0);
        step(1, 1, 1, 12'h3FF, 0);
        step(1, 0, 0, '0, 1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 19) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) < (i < 200 ? 65 : 35),
                 DW'($urandom), $urandom_range(0, 99) < 50);

        step(1, 1, 0, '0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 1, DW'($urandom), 0);
        @(negedge clk);
        en = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", cnt, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_aempty", ae, 1'b1);
        chk("rst_afull", af, 1'b0);
        chk("rst_flags", {ovf, unf, rv}, 3'b000);
        chk("rst_rdata", rd, 0);
        mq.delete();
        expq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        f_we = 1'b1; f_wd = 12'hABC;
        @(negedge clk);
        f_we = 1'b0;
        chk("fwft_data", f_rd, 12'hABC);
        chk("fwft_valid", f_rv, 1'b1);
        chk("fwft_count", f_cnt, 1);
        chk("fwft_status", {f_full, f_empty, f_af, f_ae, f_ovf}, 5'b00010);
        f_re = 1'b1;
        @(negedge clk);
        f_re = 1'b0;
        chk("fwft_pop_empty", f_empty, 1'b1);
        chk("fwft_pop_valid", f_rv, 1'b0);
        chk("fwft_hold", f_rd, 12'hABC);
        f_re = 1'b1;
        @(negedge clk);
        f_re = 1'b0;
        chk("fwft_underflow", f_unf, 1'b1);
        for (int i = 0; i < 3; i++) begin
            f_we = 1'b1; f_wd = DW'(12'h100 + i);
            @(negedge clk);
        end
        f_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fwft_seq_data", f_rd, 12'h100 + i);
            chk("fwft_seq_valid", f_rv, 1'b1);
            f_re = 1'b1;
            @(negedge clk);
        end
        f_re = 1'b0;
        chk("fwft_seq_empty", f_empty, 1'b1);
        f_we = 1'b1; f_wd = 12'h111;
        @(negedge clk);
        f_wd = 12'h222; f_re = 1'b1;
        @(negedge clk);
        f_we = 1'b0; f_re = 1'b0;
        chk("fwft_rw_data", f_rd, 12'h222);
        chk("fwft_rw_count", f_cnt, 1);

        repeat (2) @(negedge clk);
        chk("leftover_expected", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
